mmio_initiator: RTL
===================

MMIO_INITIATOR -- requirements
Module: mmio_initiator

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, MMIO address width in 32-bit word units.
REQ-002 SHALL have parameter DATA_W, default 64, MMIO data width.
REQ-003 SHALL have parameter TID_W, default 9, transaction-ID width.
REQ-004 SHALL have parameter TIMEOUT, default 256, max wait cycles for a read response (>=2).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port cmd_valid  input  1  command offered.
REQ-008 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-009 SHALL have port cmd_write  input  1  1=MMIO write, 0=MMIO read.
REQ-010 SHALL have port cmd_addr  input  ADDR_W  target MMIO address.
REQ-011 SHALL have port cmd_wdata  input  DATA_W  write data.
REQ-012 SHALL have port mmio_wr_valid  output  1  one-cycle MMIO write request strobe.
REQ-013 SHALL have port mmio_rd_valid  output  1  one-cycle MMIO read request strobe.
REQ-014 SHALL have port mmio_addr  output  ADDR_W  request address.
REQ-015 SHALL have port mmio_tid  output  TID_W  request transaction ID.
REQ-016 SHALL have port mmio_data  output  DATA_W  request write data.
REQ-017 SHALL have port rsp_valid  input  1  read-response strobe from responder.
REQ-018 SHALL have port rsp_tid  input  TID_W  transaction ID of response.
REQ-019 SHALL have port rsp_data  input  DATA_W  response data.
REQ-020 SHALL have port done_valid  output  1  one-cycle completion strobe.
REQ-021 SHALL have port done_data  output  DATA_W  read data (0 for writes/errors).
REQ-022 SHALL have port done_error  output  1  completion failed (timeout or misaligned), qualified by done_valid.
REQ-023 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-024 SHALL implement FSM states IDLE, ISSUE_WR, ISSUE_RD, WAIT_RSP, DONE.
REQ-025 cmd_ready SHALL equal 1 only in IDLE; command accepted in cycle N when cmd_valid&&cmd_ready.
REQ-026 Accepted command SHALL have addr, wdata, write captured in cycle N; later cmd_* changes have no effect.
REQ-027 Misaligned command (cmd_addr[0]=1) SHALL go IDLE->DONE: no request strobe, done_error=1, done_data=0 at N+1.
REQ-028 Aligned write SHALL go IDLE->ISSUE_WR: mmio_wr_valid=1 at N+1 with captured addr/data; done_valid=1, done_error=0, done_data=0 at N+2.
REQ-029 Aligned read SHALL go IDLE->ISSUE_RD: mmio_rd_valid=1 at N+1 with captured addr and current tid; WAIT_RSP from N+2.
REQ-030 Tid counter SHALL increment by 1 after each issued read only, wrapping 2^TID_W-1 -> 0.
REQ-031 In WAIT_RSP, rsp_valid with rsp_tid==issued tid in cycle M SHALL give done_valid=1, done_error=0, done_data=rsp_data at M+1.
REQ-032 rsp_valid with non-matching tid, or in any state other than WAIT_RSP, SHALL be ignored.
REQ-033 Wait counter SHALL clear on entry to WAIT_RSP and count WAIT_RSP cycles; with no match in TIMEOUT consecutive cycles, done_valid=1, done_error=1, done_data=0 next cycle.
REQ-034 Matching response in the final (TIMEOUT-th) wait cycle SHALL win over timeout.
REQ-035 DONE SHALL last exactly one cycle then return to IDLE; cmd_ready=1 the cycle after done_valid.
REQ-036 mmio_wr_valid, mmio_rd_valid, done_valid SHALL each be high for at most one cycle per command; never both request strobes together.
REQ-037 mmio_addr/mmio_tid/mmio_data SHALL hold last driven values when strobes low.

Reset
REQ-038 On rst high at a clock edge: state=IDLE, tid=0, wait counter=0, all strobes/done_error/busy=0, done_data/mmio_* =0; cmd_ready=1 the cycle after rst deasserts.
REQ-039 rst mid-operation SHALL abort the command with no done_valid; a later late response SHALL be ignored.

Verification
REQ-040 Write cmd addr=0x0020, wdata=0xDEADBEEF at N -> mmio_wr_valid at N+1 (addr 0x0020, data 0xDEADBEEF), done_valid err=0 data=0 at N+2, cmd_ready at N+3.
REQ-041 Read addr=0x0000 after reset -> mmio_rd_valid tid=0; rsp tid=0 data=0x1000010000000000 three cycles later -> done_data=0x1000010000000000, err=0 next cycle; next read uses tid=1.
REQ-042 During WAIT_RSP drive rsp tid=5 then tid=issued -> first ignored, completion only after second with its data.
REQ-043 Read with no response, TIMEOUT=8 -> done_valid err=1 data=0 exactly 8 wait cycles after entering WAIT_RSP; matching rsp on 8th wait cycle instead -> err=0.
REQ-044 Read addr=0x0003 -> no mmio strobe, done_valid err=1 next cycle; 512 reads -> tid wraps 511->0.
REQ-045 rst pulse in WAIT_RSP then matching rsp -> no done_valid, busy=0, tid=0.

Source files
------------

// File: rtl/mmio_initiator.sv
`default_nettype none
// ============================================================================
// Module   : mmio_initiator
// Brief    : Single-outstanding MMIO command initiator. It turns one accepted
//            command into a one-cycle read or write request strobe, matches
//            the read response by transaction ID, bounds the wait with a
//            timeout, and reports every command with a one-cycle completion.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_initiator #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 64,
    parameter int TID_W   = 9,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              mmio_wr_valid,
    output logic              mmio_rd_valid,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [TID_W-1:0]  mmio_tid,
    output logic [DATA_W-1:0] mmio_data,
    input  logic              rsp_valid,
    input  logic [TID_W-1:0]  rsp_tid,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              done_valid,
    output logic [DATA_W-1:0] done_data,
    output logic              done_error,
    output logic              busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE_WR = 3'd1;
    localparam logic [2:0] S_ISSUE_RD = 3'd2;
    localparam logic [2:0] S_WAIT_RSP = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    // Counter only needs to reach TIMEOUT-1: wait cycle k holds value k-1.
    localparam int              WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [TID_W-1:0]  tid_q;
    logic [WAIT_W-1:0] wait_q;
    logic [ADDR_W-1:0] mmio_addr_q;
    logic [TID_W-1:0]  mmio_tid_q;
    logic [DATA_W-1:0] mmio_data_q;
    logic [DATA_W-1:0] done_data_q;
    logic              done_err_q;

    logic cmd_fire;
    logic misaligned;
    logic rsp_match;
    logic wait_expired;

    // The issued tid is held in mmio_tid_q, so it doubles as the match key.
    assign cmd_fire     = cmd_valid && (state_q == S_IDLE);
    assign misaligned   = cmd_addr[0];
    assign rsp_match    = rsp_valid && (rsp_tid == mmio_tid_q);
    assign wait_expired = (wait_q == WAIT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a match in the last wait cycle beats the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    if (misaligned)     state_d = S_DONE;
                    else if (cmd_write) state_d = S_ISSUE_WR;
                    else                state_d = S_ISSUE_RD;
                end
            end
            S_ISSUE_WR: state_d = S_DONE;
            S_ISSUE_RD: state_d = S_WAIT_RSP;
            S_WAIT_RSP: begin
                if (rsp_match || wait_expired) state_d = S_DONE;
            end
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; request fields come from held registers.
    always_comb begin
        cmd_ready     = (state_q == S_IDLE);
        busy          = (state_q != S_IDLE);
        mmio_wr_valid = (state_q == S_ISSUE_WR);
        mmio_rd_valid = (state_q == S_ISSUE_RD);
        done_valid    = (state_q == S_DONE);
        done_error    = (state_q == S_DONE) && done_err_q;
        done_data     = done_data_q;
        mmio_addr     = mmio_addr_q;
        mmio_tid      = mmio_tid_q;
        mmio_data     = mmio_data_q;
    end

    // Datapath: command capture, tid/wait counters and completion payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            tid_q       <= '0;
            wait_q      <= '0;
            mmio_addr_q <= '0;
            mmio_tid_q  <= '0;
            mmio_data_q <= '0;
            done_data_q <= '0;
            done_err_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_fire) begin
                        if (misaligned) begin
                            done_data_q <= '0;
                            done_err_q  <= 1'b1;
                        end else if (cmd_write) begin
                            mmio_addr_q <= cmd_addr;
                            mmio_data_q <= cmd_wdata;
                        end else begin
                            mmio_addr_q <= cmd_addr;
                            mmio_tid_q  <= tid_q;
                        end
                    end
                end
                S_ISSUE_WR: begin
                    done_data_q <= '0;
                    done_err_q  <= 1'b0;
                end
                S_ISSUE_RD: begin
                    tid_q  <= tid_q + 1'b1;
                    wait_q <= '0;
                end
                S_WAIT_RSP: begin
                    if (rsp_match) begin
                        done_data_q <= rsp_data;
                        done_err_q  <= 1'b0;
                    end else if (wait_expired) begin
                        done_data_q <= '0;
                        done_err_q  <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
